// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Tuse/Tnew hazard unit for the 5-stage MIPS pipe. It shadows
//             the E/M/W producers and drives stall/bubble controls and the
//             D-stage and E-stage forwarding selects.
//  Option   : HAZARD_STATS_EN adds a saturating stall-cycle counter
//             (stall_cnt port).
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int NO_USE = 16
`ifdef HAZARD_STATS_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_rsT,
  input  logic [4:0] d_rtT,
  input  logic [4:0] d_T,
  input  logic       d_regw_en,
  input  logic [4:0] d_dst,
  output logic       stall,
  output logic       pc_en,
  output logic       fd_en,
  output logic       de_clr,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [5:0] c_no_use = 6'(NO_USE);

  // One in-flight producer: write-valid, destination and cycles until ready
  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic [1:0] tnew;
  } prod_t;

  prod_t      r_e, r_m, r_w;
  // Operand info of the instruction in E, needed for the E-stage selects
  logic [4:0] r_e_rs, r_e_rt, r_e_rs_t, r_e_rt_t;

  prod_t      w_d;
  logic       w_stall;

  function automatic logic f_hit(input prod_t s, input logic [4:0] r);
    return s.v && (s.dst == r) && (r != 5'd0);
  endfunction

  function automatic logic f_used(input logic [4:0] tuse);
    return {1'b0, tuse} < c_no_use;
  endfunction

  // Youngest matching producer in E or M decides; older ones are shadowed
  function automatic logic f_op_stall(input logic [4:0] r, input logic [4:0] tuse,
                                      input prod_t e, input prod_t m);
    logic st;
    st = 1'b0;
    if (f_used(tuse)) begin
      if (f_hit(e, r))      st = ({3'b000, e.tnew} > tuse);
      else if (f_hit(m, r)) st = ({3'b000, m.tnew} > tuse);
    end
    return st;
  endfunction

  // A youngest match that is not ready yet selects the GRF; E picks it up later
  function automatic logic [1:0] f_d_sel(input logic [4:0] r, input prod_t e,
                                         input prod_t m, input prod_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (f_hit(e, r))      sel = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
    else if (f_hit(m, r)) sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
    else if (f_hit(w, r)) sel = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
    return sel;
  endfunction

  function automatic logic [1:0] f_e_sel(input logic [4:0] r, input logic [4:0] tuse,
                                         input prod_t m, input prod_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (f_used(tuse)) begin
      if (f_hit(m, r) && (m.tnew == 2'd0)) sel = 2'd2;
      else if (f_hit(w, r))                sel = 2'd3;
    end
    return sel;
  endfunction

  // Producer entry for the D-stage instruction; only real GPR writes count
  always_comb begin
    w_d.v    = d_valid && d_regw_en && (d_dst != 5'd0) && (d_T <= 5'd2);
    w_d.dst  = d_dst;
    w_d.tnew = w_d.v ? d_T[1:0] : 2'd0;
  end

  // Hazard detection and forwarding selects, all from state plus D inputs
  always_comb begin
    w_stall  = f_op_stall(d_rs, d_rsT, r_e, r_m) || f_op_stall(d_rt, d_rtT, r_e, r_m);
    fwd_d_rs = f_d_sel(d_rs, r_e, r_m, r_w);
    fwd_d_rt = f_d_sel(d_rt, r_e, r_m, r_w);
    fwd_e_rs = f_e_sel(r_e_rs, r_e_rs_t, r_m, r_w);
    fwd_e_rt = f_e_sel(r_e_rt, r_e_rt_t, r_m, r_w);
  end

  assign stall  = w_stall;
  assign pc_en  = ~w_stall;
  assign fd_en  = ~w_stall;
  assign de_clr = w_stall;

  // Shadow pipeline: bubble into E on stall or empty slot, M/W always advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e      <= '0;
      r_m      <= '0;
      r_w      <= '0;
      r_e_rs   <= 5'd0;
      r_e_rt   <= 5'd0;
      r_e_rs_t <= '1;
      r_e_rt_t <= '1;
    end else begin
      r_w <= '{v: r_m.v, dst: r_m.dst, tnew: 2'd0};
      r_m <= '{v: r_e.v, dst: r_e.dst,
               tnew: (r_e.tnew == 2'd0) ? 2'd0 : (r_e.tnew - 2'd1)};
      if (w_stall || !d_valid) begin
        r_e      <= '0;
        r_e_rs   <= 5'd0;
        r_e_rt   <= 5'd0;
        r_e_rs_t <= '1;
        r_e_rt_t <= '1;
      end else begin
        r_e      <= w_d;
        r_e_rs   <= d_rs;
        r_e_rt   <= d_rt;
        r_e_rs_t <= d_rsT;
        r_e_rt_t <= d_rtT;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
